wb_arbiter_stage: RTL and testbench

//  Write-back stage directly upstream of the register file. It owns the single RF write port
//  (Dest_wb/Result_WB/writeBackEn) and arbitrates between two sources: the MEM-stage result
//  (ALU or load) and a long-latency unit (multiplier) queued in a small FIFO. It also exports

---
 rtl/wb_arbiter_stage.sv | 97 +++++++++
 tb/tb_wb_arbiter_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_stage.sv
// Write-back stage: owns the single register-file write port, arbitrating MEM-stage results
// against a small FIFO of long-latency (multiplier) results, and flags pending writes for decode.
module wb_arbiter_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_WB_EN,
    input  logic              MEM_R_EN,
    input  logic [DATA_W-1:0] ALU_Res,
    input  logic [DATA_W-1:0] Mem_read_value,
    input  logic [REG_W-1:0]  MEM_Dest,
    input  logic              mul_valid,
    input  logic [REG_W-1:0]  mul_dest,
    input  logic [DATA_W-1:0] mul_result,
    output logic              mul_ready,
    input  logic [REG_W-1:0]  hz_src1,
    input  logic [REG_W-1:0]  hz_src2,
    input  logic [REG_W-1:0]  hz_dest,
    output logic              hz_hit,
    output logic [REG_W-1:0]  Dest_wb,
    output logic [DATA_W-1:0] Result_WB,
    output logic              writeBackEn
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [REG_W-1:0] PC_IDX = REG_W'(15);

    logic [REG_W-1:0]     q_dest [FIFO_DEPTH];
    logic [DATA_W-1:0]    q_data [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [FIFO_DEPTH-1:0] entry_valid;

    logic mem_take;
    logic fifo_nonempty;
    logic pop;
    logic enq;

    assign mem_take      = MEM_WB_EN && (MEM_Dest != PC_IDX);
    assign fifo_nonempty = (count != '0);
    assign pop           = !mem_take && fifo_nonempty;
    assign mul_ready     = rst && (count < CNT_W'(FIFO_DEPTH));
    // Handshake completes for PC-destined results, but they never occupy a slot.
    assign enq           = mul_valid && mul_ready && (mul_dest != PC_IDX);

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        hz_hit      = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < count);
            if (entry_valid[i] &&
                ((q_dest[i] == hz_src1) || (q_dest[i] == hz_src2) || (q_dest[i] == hz_dest)))
                hz_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_dest[wr_ptr] <= mul_dest;
            q_data[wr_ptr] <= mul_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            Dest_wb     <= '0;
            Result_WB   <= '0;
            writeBackEn <= 1'b0;
        end else begin
            writeBackEn <= mem_take || pop;
            if (mem_take) begin
                Dest_wb   <= MEM_Dest;
                Result_WB <= MEM_R_EN ? Mem_read_value : ALU_Res;
            end else if (pop) begin
                Dest_wb   <= q_dest[rd_ptr];
                Result_WB <= q_data[rd_ptr];
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed bench for wb_arbiter_stage: expected RF writes (with their due cycle) are queued as
// stimulus is driven and matched against every cycle in which writeBackEn is seen high.
module tb_wb_arbiter_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_WB_EN, MEM_R_EN;
    logic [31:0] ALU_Res, Mem_read_value;
    logic [3:0]  MEM_Dest;
    logic        mul_valid;
    logic [3:0]  mul_dest;
    logic [31:0] mul_result;
    logic        mul_ready;
    logic [3:0]  hz_src1, hz_src2, hz_dest;
    logic        hz_hit;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic        writeBackEn;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  dest;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    wb_arbiter_stage #(.DATA_W(32), .REG_W(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .MEM_WB_EN(MEM_WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_Res(ALU_Res),
        .Mem_read_value(Mem_read_value), .MEM_Dest(MEM_Dest),
        .mul_valid(mul_valid), .mul_dest(mul_dest), .mul_result(mul_result),
        .mul_ready(mul_ready),
        .hz_src1(hz_src1), .hz_src2(hz_src2), .hz_dest(hz_dest), .hz_hit(hz_hit),
        .Dest_wb(Dest_wb), .Result_WB(Result_WB), .writeBackEn(writeBackEn)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input int c, input logic [3:0] d, input logic [31:0] v);
        wb_t e;
        e.cyc  = c;
        e.dest = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // Advance one edge, then match any RF write against the head of the scoreboard.
    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (writeBackEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", {63'b0, writeBackEn}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_cycle", 64'(cyc), 64'(e.cyc));
                check("wb_dest", {60'b0, Dest_wb}, {60'b0, e.dest});
                check("wb_data", {32'b0, Result_WB}, {32'b0, e.data});
            end
        end
    endtask

    task automatic mem_idle();
        MEM_WB_EN = 1'b0;
        MEM_R_EN  = 1'b0;
    endtask

    task automatic mem_drive(input logic r_en, input logic [3:0] d, input logic [31:0] alu,
                             input logic [31:0] ld);
        MEM_WB_EN      = 1'b1;
        MEM_R_EN       = r_en;
        MEM_Dest       = d;
        ALU_Res        = alu;
        Mem_read_value = ld;
    endtask

    initial begin
        rst = 1'b0;
        mem_idle();
        ALU_Res = '0; Mem_read_value = '0; MEM_Dest = '0;
        mul_valid = 1'b0; mul_dest = '0; mul_result = '0;
        hz_src1 = 4'd14; hz_src2 = 4'd14; hz_dest = 4'd14;

        // Reset state
        #7;
        check("rst_wben", {63'b0, writeBackEn}, 64'd0);
        check("rst_dest", {60'b0, Dest_wb}, 64'd0);
        check("rst_data", {32'b0, Result_WB}, 64'd0);
        check("rst_ready", {63'b0, mul_ready}, 64'd0);
        check("rst_hz", {63'b0, hz_hit}, 64'd0);
        rst = 1'b1;
        #1;
        check("rel_ready", {63'b0, mul_ready}, 64'd1);
        tick();

        // 1: MEM path, ALU then load select, then hold when idle
        mem_drive(1'b0, 4'd3, 32'h1234, 32'h0);
        expect_wb(cyc + 1, 4'd3, 32'h1234);
        tick();
        check("t1_wben", {63'b0, writeBackEn}, 64'd1);
        mem_drive(1'b1, 4'd3, 32'h1234, 32'hBEEF);
        expect_wb(cyc + 1, 4'd3, 32'hBEEF);
        tick();
        mem_idle();
        tick();
        check("t1_idle_wben", {63'b0, writeBackEn}, 64'd0);
        check("t1_hold_dest", {60'b0, Dest_wb}, 64'd3);
        check("t1_hold_data", {32'b0, Result_WB}, 64'hBEEF);

        // 2: single mul result through the FIFO, hazard visible while queued
        mul_valid = 1'b1; mul_dest = 4'd5; mul_result = 32'd99; hz_src2 = 4'd5;
        #1;
        check("t2_ready", {63'b0, mul_ready}, 64'd1);
        check("t2_hz_empty", {63'b0, hz_hit}, 64'd0);
        expect_wb(cyc + 2, 4'd5, 32'd99);
        tick();
        mul_valid = 1'b0;
        #1;
        check("t2_no_wb_yet", {63'b0, writeBackEn}, 64'd0);
        check("t2_hz_queued", {63'b0, hz_hit}, 64'd1);
        tick();
        check("t2_hz_after", {63'b0, hz_hit}, 64'd0);
        hz_src2 = 4'd14;

        // 3: MEM owns the port for 4 cycles while two mul results queue up
        mem_drive(1'b0, 4'd8, 32'hA0, 32'h0);
        mul_valid = 1'b1; mul_dest = 4'd6; mul_result = 32'd66;
        #1;
        check("t3_ready0", {63'b0, mul_ready}, 64'd1);
        expect_wb(cyc + 1, 4'd8, 32'hA0);
        tick();
        mem_drive(1'b0, 4'd9, 32'hA1, 32'h0);
        mul_dest = 4'd7; mul_result = 32'd77;
        #1;
        check("t3_ready1", {63'b0, mul_ready}, 64'd1);
        expect_wb(cyc + 1, 4'd9, 32'hA1);
        tick();
        mul_valid = 1'b0;
        mem_drive(1'b0, 4'd10, 32'hA2, 32'h0);
        #1;
        check("t3_full", {63'b0, mul_ready}, 64'd0);
        expect_wb(cyc + 1, 4'd10, 32'hA2);
        tick();
        mem_drive(1'b0, 4'd11, 32'hA3, 32'h0);
        expect_wb(cyc + 1, 4'd11, 32'hA3);
        expect_wb(cyc + 2, 4'd6, 32'd66);
        expect_wb(cyc + 3, 4'd7, 32'd77);
        tick();
        mem_idle();
        hz_src1 = 4'd7;
        #1;
        check("t3_no_passthru", {63'b0, mul_ready}, 64'd0);
        check("t3_hz", {63'b0, hz_hit}, 64'd1);
        tick();
        check("t3_ready_back", {63'b0, mul_ready}, 64'd1);
        tick();
        tick();
        check("t3_drained", {63'b0, writeBackEn}, 64'd0);
        check("t3_hz_clear", {63'b0, hz_hit}, 64'd0);
        hz_src1 = 4'd14;

        // 4: PC-destined MEM write is dropped and the FIFO drains; PC-destined mul push vanishes
        mem_drive(1'b0, 4'd12, 32'hC0, 32'h0);
        mul_valid = 1'b1; mul_dest = 4'd2; mul_result = 32'd22;
        expect_wb(cyc + 1, 4'd12, 32'hC0);
        tick();
        mem_drive(1'b0, 4'd15, 32'hDEAD, 32'h0);
        mul_dest = 4'd15; mul_result = 32'd55;
        #1;
        check("t4_ready", {63'b0, mul_ready}, 64'd1);
        expect_wb(cyc + 1, 4'd2, 32'd22);
        tick();
        check("t4_pc_drop_dest", {60'b0, Dest_wb}, 64'd2);
        mul_valid = 1'b0;
        mem_idle();
        hz_src1 = 4'd15;
        #1;
        check("t4_pc_not_queued", {63'b0, hz_hit}, 64'd0);
        tick();
        check("t4_no_pc_wb", {63'b0, writeBackEn}, 64'd0);
        hz_src1 = 4'd14;

        // 5: fill the FIFO behind MEM traffic, then reset mid-cycle
        mem_drive(1'b0, 4'd1, 32'd11, 32'h0);
        mul_valid = 1'b1; mul_dest = 4'd4; mul_result = 32'd44;
        expect_wb(cyc + 1, 4'd1, 32'd11);
        tick();
        mem_drive(1'b0, 4'd1, 32'd12, 32'h0);
        mul_dest = 4'd13; mul_result = 32'd133;
        expect_wb(cyc + 1, 4'd1, 32'd12);
        tick();
        mul_valid = 1'b0;
        mem_drive(1'b0, 4'd1, 32'd13, 32'h0);
        hz_src1 = 4'd4;
        #1;
        check("t5_full", {63'b0, mul_ready}, 64'd0);
        check("t5_hz", {63'b0, hz_hit}, 64'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_wben", {63'b0, writeBackEn}, 64'd0);
        check("t5_rst_hz", {63'b0, hz_hit}, 64'd0);
        check("t5_rst_ready", {63'b0, mul_ready}, 64'd0);
        mem_idle();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rel_ready", {63'b0, mul_ready}, 64'd1);
        check("t5_rel_hz", {63'b0, hz_hit}, 64'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check("t5_no_stale", {63'b0, writeBackEn}, 64'd0);
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
